// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the bit-stream frame synchroniser.
// Polarity resolution is enabled with BPSK_POLARITY_RESOLVE_EN.
package rx_frame_pkg;
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LENGTH  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hD391;
  localparam int          LEN_WIDTH     = 8;
endpackage

// File: rtl/sync_correlator.sv
// Popcount-threshold match of a shift window against the sync pattern.
// With BPSK_POLARITY_RESOLVE_EN the inverse pattern is matched as well.
module sync_correlator #(
  parameter int             W       = 16,
  parameter logic [W-1:0]   PATTERN = 16'hD391,
  parameter int             TOL     = 0
) (
  input  logic [W-1:0] i_shift,
  output logic         o_match
`ifdef BPSK_POLARITY_RESOLVE_EN
  ,
  output logic         o_match_inv
`endif
);
  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] w_dist;

  always_comb begin
    w_dist = '0;
    for (int i = 0; i < W; i++) begin
      w_dist = w_dist + CW'(i_shift[i] ^ PATTERN[i]);
    end
  end

  assign o_match = (int'(w_dist) <= TOL);

`ifdef BPSK_POLARITY_RESOLVE_EN
  // Every bit that differs from PATTERN agrees with ~PATTERN.
  assign o_match_inv = (int'(W) - int'(w_dist) <= TOL);
`endif
endmodule

// File: rtl/bit_frame_sync.sv
// Sync-word hunt, length/payload deframing and strobe timeout abort.
// Define BPSK_POLARITY_RESOLVE_EN to accept inverted streams.
module bit_frame_sync
  import rx_frame_pkg::*;
#(
  parameter int                    SYNC_WIDTH     = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD      = SYNC_WORD_DEF,
  parameter int                    SYNC_TOLERANCE = 0,
  parameter int                    TIMEOUT        = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic [LEN_WIDTH-1:0] byte_out,
  output logic                 byte_valid,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic                 frame_abort,
  output logic                 locked
`ifdef BPSK_POLARITY_RESOLVE_EN
  ,
  output logic                 inverted
`endif
);
  localparam int FW = $clog2(SYNC_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t r_state, w_state_nxt;

  logic [SYNC_WIDTH-1:0] r_shift;
  logic [SYNC_WIDTH-1:0] w_shift_nxt;
  logic [FW-1:0]         r_fill;
  logic [2:0]            r_bit_cnt;
  logic [LEN_WIDTH-1:0]  r_data;
  logic [LEN_WIDTH-1:0]  r_byte_cnt;
  logic [LEN_WIDTH-1:0]  r_byte_out;
  logic [TW-1:0]         r_to_cnt;
  logic                  r_first;
  logic                  r_byte_valid;
  logic                  r_start;
  logic                  r_end;
  logic                  r_abort;
  logic                  r_inv;

  logic                 w_match, w_match_inv;
  logic                 w_armed, w_expire;
  logic                 w_lock, w_lock_inv;
  logic                 w_byte_done, w_frame_done;
  logic                 w_to_hunt;
  logic                 w_last_bit;
  logic [LEN_WIDTH-1:0] w_byte;

  assign w_shift_nxt = {r_shift[SYNC_WIDTH-2:0], bit_in};
  assign w_armed     = (r_fill >= FW'(SYNC_WIDTH - 1));
  assign w_last_bit  = bit_valid && (r_bit_cnt == 3'd7);
  assign w_byte      = {r_data[LEN_WIDTH-2:0], bit_in ^ r_inv};
  assign w_expire    = (r_state != HUNT) && !bit_valid &&
                       (r_to_cnt == TW'(TIMEOUT - 1));
  assign w_to_hunt   = (r_state != HUNT) && (w_state_nxt == HUNT);

  sync_correlator #(
    .W       (SYNC_WIDTH),
    .PATTERN (SYNC_WORD),
    .TOL     (SYNC_TOLERANCE)
  ) u_corr (
    .i_shift     (w_shift_nxt),
    .o_match     (w_match)
`ifdef BPSK_POLARITY_RESOLVE_EN
    ,
    .o_match_inv (w_match_inv)
`endif
  );

`ifndef BPSK_POLARITY_RESOLVE_EN
  assign w_match_inv = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= HUNT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_lock       = 1'b0;
    w_lock_inv   = 1'b0;
    w_byte_done  = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (bit_valid && w_armed) begin
          // True polarity wins when both patterns match.
          w_lock     = w_match || w_match_inv;
          w_lock_inv = !w_match && w_match_inv;
          if (w_lock) w_state_nxt = LENGTH;
        end
      end
      LENGTH: begin
        if (w_expire) begin
          w_state_nxt = HUNT;
        end else if (w_last_bit) begin
          w_state_nxt = (w_byte == '0) ? HUNT : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (w_expire) begin
          w_state_nxt = HUNT;
        end else if (w_last_bit) begin
          w_byte_done = 1'b1;
          if (r_byte_cnt == 8'd1) begin
            w_frame_done = 1'b1;
            w_state_nxt  = HUNT;
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift      <= '0;
      r_fill       <= '0;
      r_bit_cnt    <= '0;
      r_data       <= '0;
      r_byte_cnt   <= '0;
      r_byte_out   <= '0;
      r_to_cnt     <= '0;
      r_first      <= 1'b0;
      r_byte_valid <= 1'b0;
      r_start      <= 1'b0;
      r_end        <= 1'b0;
      r_abort      <= 1'b0;
      r_inv        <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_start      <= 1'b0;
      r_end        <= 1'b0;
      r_abort      <= w_expire;

      if (bit_valid) r_shift <= w_shift_nxt;

      if (w_to_hunt) begin
        r_fill <= '0;
      end else if (r_state == HUNT && bit_valid && !w_armed) begin
        r_fill <= r_fill + FW'(1);
      end

      if (r_state == HUNT) begin
        r_bit_cnt <= '0;
      end else if (bit_valid) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_data    <= w_byte;
      end

      if (r_state == LENGTH && w_last_bit) begin
        r_byte_cnt <= w_byte;
        r_first    <= 1'b1;
      end

      if (w_byte_done) begin
        r_byte_out   <= w_byte;
        r_byte_valid <= 1'b1;
        r_start      <= r_first;
        r_end        <= w_frame_done;
        r_first      <= 1'b0;
        r_byte_cnt   <= r_byte_cnt - 8'd1;
      end

      if (r_state == HUNT || bit_valid || w_expire) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end

      if (w_lock)         r_inv <= w_lock_inv;
      else if (w_to_hunt) r_inv <= 1'b0;
    end
  end

  assign byte_out    = r_byte_out;
  assign byte_valid  = r_byte_valid;
  assign frame_start = r_start;
  assign frame_end   = r_end;
  assign frame_abort = r_abort;
  assign locked      = (r_state != HUNT);
`ifdef BPSK_POLARITY_RESOLVE_EN
  assign inverted    = r_inv;
`endif
endmodule

// File: doc/bit_frame_sync.md
Name: bit_frame_sync

Overview:
- Sits directly downstream of the BPSK signal demodulator and consumes its per-symbol `guess` bit and `write` strobe.
- Hunts the bit stream for a sync word, then reads a length byte and deframes the payload into bytes.
- Emits bytes with valid/start/end markers to the receiver byte sink.
- Aborts a frame on bit-strobe timeout.

Parameters:
- SYNC_WIDTH, 16, sync word length in bits.
- SYNC_WORD, 16'hD391, pattern matched MSB-first.
- SYNC_TOLERANCE, 0, maximum Hamming distance accepted as a match.
- TIMEOUT, 1024, clk cycles allowed between bit strobes inside a frame before abort.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- bit_in  in  1  demodulated bit (demodulator `guess`), sampled only when bit_valid=1.
- bit_valid  in  1  one-cycle bit strobe (demodulator `write`).
- byte_out  out  8  assembled byte, MSB received first.
- byte_valid  out  1  one-cycle pulse; byte_out valid.
- frame_start  out  1  pulse coincident with byte_valid of the first payload byte.
- frame_end  out  1  pulse coincident with byte_valid of the last payload byte.
- frame_abort  out  1  one-cycle pulse on timeout abort.
- locked  out  1  high from sync detection until frame end or abort.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state HUNT; shift register, bit counter, byte counter and timeout counter cleared.
- Shift register: SYNC_WIDTH bits; on bit_valid, shift left with bit_in entering at LSB. Active in every state.
- HUNT:
  - On a bit_valid cycle, compute popcount(next_shift XOR SYNC_WORD), where next_shift includes the current bit.
  - If popcount <= SYNC_TOLERANCE: go to LENGTH, set locked=1, clear bit counter.
  - Matching is gated until at least SYNC_WIDTH bits have been shifted since reset or since the last return to HUNT.
- LENGTH: collect 8 bits into len register.
  - On the 8th bit, if len==0: return to HUNT, locked=0, no other outputs.
  - Otherwise go to PAYLOAD and set byte count = len.
- PAYLOAD: collect 8 bits per byte.
  - On the 8th bit, byte_out and byte_valid are registered and visible the cycle after the strobe edge (1-cycle latency).
  - frame_start is asserted with the first byte.
  - frame_end is asserted with byte number len; on that edge return to HUNT, locked=0.
  - A single-byte frame asserts frame_start and frame_end together.
- Timeout:
  - In LENGTH or PAYLOAD, a counter increments each cycle without bit_valid and clears on bit_valid.
  - When it reaches TIMEOUT-1 with no strobe: frame_abort pulses, locked=0, go to HUNT, partial byte discarded, no frame_end.
  - A strobe arriving in the same cycle as expiry wins; no abort.
- Sync search is suspended while locked. Payload bits are never matched as sync.
- Bit strobes back-to-back on every cycle are legal. The block has no backpressure; byte_valid may pulse every 8 cycles.
- Counter widths: bit counter 3 bits (wraps 7→0); byte counter 8 bits; timeout counter $clog2(TIMEOUT)+1 bits.
- Reset mid-frame: immediate return to HUNT, outputs cleared, no abort pulse.

Optional Feature:
- Macro: BPSK_POLARITY_RESOLVE_EN.
- Enabled:
  - HUNT also matches ~SYNC_WORD under the same tolerance; the true pattern takes priority if both match.
  - An inverted match sets output `inverted`=1 (extra 1-bit port), held until return to HUNT.
  - While inverted=1, every bit is complemented before entering length and payload assembly.
- Disabled: `inverted` port absent; only the true pattern matches.

Decomposition:
- Shared package `rx_frame_pkg`: state enum typedef (HUNT, LENGTH, PAYLOAD), default SYNC_WORD constant, LEN_WIDTH=8.
- Sub-module `sync_correlator`: combinational popcount-threshold match of the shift register against the pattern (and its inverse when enabled). Instantiated once.

Test Plan:
- Clean frame: bits D391, 03, A5, 5A, C3, strobed every 8 cycles → bytes A5, 5A, C3; frame_start on A5; frame_end on C3; locked falls the cycle after C3 and stays 0 while the line idles.
- Length zero: D391 then 00 → no byte_valid, locked 1→0 after the 8th length bit, HUNT resumes and a following D391,01,7E yields single byte 7E with frame_start=frame_end=1.
- Tolerance: SYNC_TOLERANCE=1; D393 (1 bit off) → lock; D397 (2 bits off) → no lock.
- Timeout: TIMEOUT=16; D391, 02, 11 then 20 idle cycles → byte 11 only, frame_abort one pulse at idle cycle 16, no frame_end.
- Reset mid-payload: deassert reset_n during byte 2 of a 4-byte frame → all outputs 0 immediately; a new frame afterwards decodes correctly.
- BPSK_POLARITY_RESOLVE_EN: complemented stream 2C6E, FE, 5A (inverse of D391, 01, A5) → inverted=1, byte A5 with frame_start/frame_end; with the macro off, the same stimulus gives no lock.
